// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline field widths, stage payload types and stage state encoding
// Purpose: common definitions for the P5+ inter-stage registers.
//   Field widths, per-stage payload structs with pack/unpack helpers, NOP encoding
//   and the occupancy state of a pipeline stage register (EMPTY/ONE/TWO == level).
// Ports: none (package).
package pipe_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int WORD_W  = 32;
    localparam int REG_W   = 5;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;

    // Encoding doubles as the externally visible occupancy level.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc4;
    } if_id_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc4;
        logic [WORD_W-1:0]  alu_out;
        logic [WORD_W-1:0]  store_data;
        logic [REG_W-1:0]   write_reg;
    } ex_mem_t;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc4;
        logic [WORD_W-1:0]  alu_out;
        logic [WORD_W-1:0]  dm_data;
        logic [REG_W-1:0]   write_reg;
    } mem_wb_t;

    localparam int IF_ID_W  = $bits(if_id_t);
    localparam int EX_MEM_W = $bits(ex_mem_t);
    localparam int MEM_WB_W = $bits(mem_wb_t);

    function automatic logic [IF_ID_W-1:0] pack_if_id(input if_id_t p);
        return p;
    endfunction

    function automatic if_id_t unpack_if_id(input logic [IF_ID_W-1:0] v);
        return if_id_t'(v);
    endfunction

    function automatic logic [EX_MEM_W-1:0] pack_ex_mem(input ex_mem_t p);
        return p;
    endfunction

    function automatic ex_mem_t unpack_ex_mem(input logic [EX_MEM_W-1:0] v);
        return ex_mem_t'(v);
    endfunction

    function automatic logic [MEM_WB_W-1:0] pack_mem_wb(input mem_wb_t p);
        return p;
    endfunction

    function automatic mem_wb_t unpack_mem_wb(input logic [MEM_WB_W-1:0] v);
        return mem_wb_t'(v);
    endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// rtl/pipe_stage_skid_if.sv - valid/ready payload handshake bundle between pipeline stages
// Purpose: one direction of a stage-to-stage link.
// Signals: valid (producer), ready (consumer), data [DATA_W] (producer).
// Modports: master = producer side, slave = consumer side.
interface pipe_stage_skid_if #(
    parameter int DATA_W = 133
) ();
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// rtl/pipe_sat_counter.sv - saturating event counter for the performance monitor
// Purpose: counts cycles where inc=1, sticks at all-ones, cleared by clr.
// Ports: clk (in), clr (in, synchronous clear), inc (in), cnt (out, CNT_W).
module pipe_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_cnt <= '0;
        end else if (inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// rtl/pipe_stage_skid.sv - inter-stage pipeline register with optional 2-entry skid buffer
// Purpose: registers one payload between pipeline stages with valid/ready flow control,
//   synchronous flush and a saturating stall-cycle counter.
// Ports:
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high, clears every register
//   flush      in   synchronous kill of all held entries
//   s_in       slave  upstream valid/ready/data
//   m_out      master downstream valid/ready/data (data = RESET_VALUE when not valid)
//   level      out  entries held (0..2)
//   stall_cnt  out  cycles with out valid and not ready, saturating
module pipe_stage_skid
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 133,
    parameter logic [DATA_W-1:0] RESET_VALUE = '0,
    parameter int                SKID        = 1,
    parameter int                CNT_W       = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    pipe_stage_skid_if.slave  s_in,
    pipe_stage_skid_if.master m_out,
    output logic [1:0]        level,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] S_EMPTY = 2'(EMPTY);
    localparam logic [1:0] S_ONE   = 2'(ONE);
    localparam logic [1:0] S_TWO   = 2'(TWO);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] r_main_data;
    logic [DATA_W-1:0] w_main_nxt;
    logic [DATA_W-1:0] w_skid_q;
    logic [DATA_W-1:0] w_skid_nxt;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_out_valid = (r_state != S_EMPTY);
    assign w_in_xfer   = s_in.valid & w_in_ready;
    assign w_out_xfer  = w_out_valid & m_out.ready;

    // Next-state/payload selection. in_data is only ever selected on an accepted
    // transfer, so an unknown payload with valid low never reaches a register.
    always_comb begin
        w_state_nxt = r_state;
        w_main_nxt  = r_main_data;
        w_skid_nxt  = w_skid_q;
        case (r_state)
            S_EMPTY: begin
                if (w_in_xfer) begin
                    w_state_nxt = S_ONE;
                    w_main_nxt  = s_in.data;
                end
            end
            S_ONE: begin
                if (w_in_xfer && w_out_xfer) begin
                    w_main_nxt = s_in.data;
                end else if (w_in_xfer && (SKID != 0)) begin
                    w_state_nxt = S_TWO;
                    w_skid_nxt  = s_in.data;
                end else if (w_out_xfer) begin
                    w_state_nxt = S_EMPTY;
                    w_main_nxt  = RESET_VALUE;
                end
            end
            S_TWO: begin
                if (w_out_xfer) begin
                    w_state_nxt = S_ONE;
                    w_main_nxt  = w_skid_q;
                    w_skid_nxt  = RESET_VALUE;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
                w_main_nxt  = RESET_VALUE;
                w_skid_nxt  = RESET_VALUE;
            end
        endcase
        // Flush wins over any same-cycle accept; an out-transfer this cycle has
        // still been delivered downstream.
        if (flush) begin
            w_state_nxt = S_EMPTY;
            w_main_nxt  = RESET_VALUE;
            w_skid_nxt  = RESET_VALUE;
        end
    end

    // Main register: bubbles are written as RESET_VALUE so out_data comes
    // straight from the flop with no output mux.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_EMPTY;
            r_main_data <= RESET_VALUE;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_nxt;
        end
    end

    generate
        if (SKID != 0) begin : g_skid
            logic [DATA_W-1:0] r_skid_data;
            logic              r_in_ready;

            // in_ready is registered from the next level so the upstream stage
            // never sees a combinational path from out_ready.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_skid_data <= RESET_VALUE;
                    r_in_ready  <= 1'b1;
                end else begin
                    r_skid_data <= w_skid_nxt;
                    r_in_ready  <= (w_state_nxt != S_TWO);
                end
            end

            assign w_skid_q   = r_skid_data;
            assign w_in_ready = r_in_ready;
        end else begin : g_noskid
            assign w_skid_q   = RESET_VALUE;
            assign w_in_ready = ~w_out_valid | m_out.ready;
        end
    endgenerate

    pipe_sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk (clk),
        .clr (reset),
        .inc (w_out_valid & ~m_out.ready),
        .cnt (stall_cnt)
    );

    assign s_in.ready  = w_in_ready;
    assign m_out.valid = w_out_valid;
    assign m_out.data  = r_main_data;
    assign level       = r_state;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// tb/tb_pipe_stage_skid.sv - directed and scoreboard bench for pipe_stage_skid
module tb_pipe_stage_skid;

    localparam int DW = 133;
    localparam int ZW = 16;
    typedef logic [DW-1:0] cv_t;

    localparam cv_t VA = {5'h11, 128'hA0A0};
    localparam cv_t VB = {5'h12, 128'hB1B1};
    localparam cv_t VC = {5'h13, 128'hC2C2};
    localparam cv_t VD = {5'h14, 128'hD3D3};
    localparam cv_t VE = {5'h15, 128'hE4E4};
    localparam cv_t VF = {5'h16, 128'hF5F5};

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          out_ready;
    logic [DW-1:0] in_data;
    logic          z_in_valid;
    logic          z_out_ready;
    logic [ZW-1:0] z_in_data;

    logic [1:0]  level_a;
    logic [1:0]  level_b;
    logic [1:0]  level_z;
    logic [15:0] stall_a;
    logic [2:0]  stall_b;
    logic [15:0] stall_z;

    int total = 0;
    int bad   = 0;

    pipe_stage_skid_if #(.DATA_W(DW)) if_a_in ();
    pipe_stage_skid_if #(.DATA_W(DW)) if_a_out ();
    pipe_stage_skid_if #(.DATA_W(DW)) if_b_in ();
    pipe_stage_skid_if #(.DATA_W(DW)) if_b_out ();
    pipe_stage_skid_if #(.DATA_W(ZW)) if_z_in ();
    pipe_stage_skid_if #(.DATA_W(ZW)) if_z_out ();

    assign if_a_in.valid  = in_valid;
    assign if_a_in.data   = in_data;
    assign if_a_out.ready = out_ready;
    assign if_b_in.valid  = in_valid;
    assign if_b_in.data   = in_data;
    assign if_b_out.ready = out_ready;
    assign if_z_in.valid  = z_in_valid;
    assign if_z_in.data   = z_in_data;
    assign if_z_out.ready = z_out_ready;

    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(16)) u_dut_a (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .s_in      (if_a_in),
        .m_out     (if_a_out),
        .level     (level_a),
        .stall_cnt (stall_a)
    );

    pipe_stage_skid #(.DATA_W(DW), .SKID(1), .CNT_W(3)) u_dut_b (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .s_in      (if_b_in),
        .m_out     (if_b_out),
        .level     (level_b),
        .stall_cnt (stall_b)
    );

    pipe_stage_skid #(.DATA_W(ZW), .SKID(0), .CNT_W(16)) u_dut_z (
        .clk       (clk),
        .reset     (reset),
        .flush     (1'b0),
        .s_in      (if_z_in),
        .m_out     (if_z_out),
        .level     (level_z),
        .stall_cnt (stall_z)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input cv_t act, input cv_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic ov, input cv_t od,
                         input logic [1:0] lv, input logic ir);
        chk({tag, "_ovalid"}, cv_t'(if_a_out.valid), cv_t'(ov));
        chk({tag, "_odata"},  if_a_out.data, od);
        chk({tag, "_level"},  cv_t'(level_a), cv_t'(lv));
        chk({tag, "_iready"}, cv_t'(if_a_in.ready), cv_t'(ir));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [ZW-1:0] q[$];
        logic          m_valid;
        logic          exp_rdy;

        reset       = 1'b1;
        flush       = 1'b0;
        in_valid    = 1'b1;
        in_data     = '1;
        out_ready   = 1'b0;
        z_in_valid  = 1'b0;
        z_in_data   = '0;
        z_out_ready = 1'b0;

        // Reset held 3 cycles with valid all-ones input
        step();
        chk_a("rst", 1'b0, '0, 2'd0, 1'b1);
        chk("rst_stall", cv_t'(stall_a), '0);
        step();
        step();
        chk_a("rst3", 1'b0, '0, 2'd0, 1'b1);
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;

        // Streaming 1..100 with 1-cycle latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            in_data = cv_t'(k);
            step();
            chk_a("stream", 1'b1, cv_t'(k), 2'd1, 1'b1);
        end
        in_valid = 1'b0;
        step();
        chk_a("drain", 1'b0, '0, 2'd0, 1'b1);
        chk("stream_stall", cv_t'(stall_a), '0);

        // Back-pressure: A to main, B to skid, C held upstream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = VA;
        step();
        chk_a("bp_a", 1'b1, VA, 2'd1, 1'b1);
        in_data = VB;
        step();
        chk_a("bp_b", 1'b1, VA, 2'd2, 1'b0);
        in_data = VC;
        step();
        chk_a("bp_hold1", 1'b1, VA, 2'd2, 1'b0);
        step();
        chk_a("bp_hold2", 1'b1, VA, 2'd2, 1'b0);
        chk("bp_stall_a", cv_t'(stall_a), cv_t'(3));
        chk("bp_stall_b", cv_t'(stall_b), cv_t'(3));
        out_ready = 1'b1;
        step();
        chk_a("bp_out_b", 1'b1, VB, 2'd1, 1'b1);
        step();
        chk_a("bp_out_c", 1'b1, VC, 2'd1, 1'b1);
        in_valid = 1'b0;
        step();
        chk_a("bp_empty", 1'b0, '0, 2'd0, 1'b1);
        chk("bp_stall_end", cv_t'(stall_a), cv_t'(3));

        // Flush with level 2 and a same-cycle offer of D
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = VE;
        step();
        in_data = VF;
        step();
        chk_a("fl_fill", 1'b1, VE, 2'd2, 1'b0);
        in_data = VD;
        flush   = 1'b1;
        step();
        chk_a("flush2", 1'b0, '0, 2'd0, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk_a("flush2_after", 1'b0, '0, 2'd0, 1'b1);

        // Flush at level 1 while in_ready=1: accepted-looking D must be dropped
        in_valid = 1'b1;
        in_data  = VE;
        step();
        chk_a("fl1_fill", 1'b1, VE, 2'd1, 1'b1);
        in_data = VD;
        flush   = 1'b1;
        step();
        chk_a("flush1", 1'b0, '0, 2'd0, 1'b1);
        flush    = 1'b0;
        in_valid = 1'b0;
        step();
        chk_a("flush1_after", 1'b0, '0, 2'd0, 1'b1);

        // Stall counting and saturation
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rst2_stall_a", cv_t'(stall_a), '0);
        chk("rst2_stall_b", cv_t'(stall_b), '0);
        in_valid = 1'b1;
        in_data  = VA;
        step();
        in_valid = 1'b0;
        chk("st0", cv_t'(stall_a), '0);
        repeat (5) step();
        chk("st5_a", cv_t'(stall_a), cv_t'(5));
        chk("st5_b", cv_t'(stall_b), cv_t'(5));
        repeat (5) step();
        chk("st10_a", cv_t'(stall_a), cv_t'(10));
        chk("st10_b_sat", cv_t'(stall_b), cv_t'(7));
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("st_fl_valid", cv_t'(if_a_out.valid), '0);
        chk("st_fl_a", cv_t'(stall_a), cv_t'(11));
        chk("st_fl_b", cv_t'(stall_b), cv_t'(7));
        step();
        chk("st_idle_a", cv_t'(stall_a), cv_t'(11));
        chk("st_idle_b", cv_t'(stall_b), cv_t'(7));

        // SKID=0 random traffic against a queue scoreboard
        m_valid = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            z_in_valid  = 1'($urandom_range(0, 1));
            z_out_ready = 1'($urandom_range(0, 1));
            z_in_data   = z_in_valid ? ZW'($urandom) : 'x;
            #1;
            exp_rdy = ~m_valid | z_out_ready;
            chk("z_ready", cv_t'(if_z_in.ready), cv_t'(exp_rdy));
            chk("z_valid", cv_t'(if_z_out.valid), cv_t'(m_valid));
            chk("z_data", cv_t'(if_z_out.data), m_valid ? cv_t'(q[0]) : '0);
            chk("z_level", cv_t'(level_z), cv_t'(m_valid));
            if (m_valid && z_out_ready) begin
                void'(q.pop_front());
            end
            if (z_in_valid && exp_rdy) begin
                q.push_back(z_in_data);
            end
            m_valid = (q.size() != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
